// File: rtl/nrisc_irq_ctrl_pkg.sv
// Shared constants for the NRISC interrupt controller: bus widths, the
// default register window base, register word offsets and FSM encodings.
package nrisc_irq_ctrl_pkg;

    localparam int TAM_DEFAULT     = 16;
    localparam int N_DDATA_DEFAULT = 16;

    localparam logic [15:0] BASE_ADDR_DEFAULT = 16'hFF00;

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_EOI  = 2'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // One-hot mask for a 3-bit channel index, used to clear a single PEND bit
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] result;
        result      = 8'h00;
        result[idx] = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/nrisc_prio_enc8.sv
// Fixed-priority 8-to-3 encoder: the lowest set request index wins.
// Kept standalone so other arbiters can reuse it.
module nrisc_prio_enc8 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nrisc_irq_ctrl.sv
// NRISC interrupt controller: edge-latches eight request lines into PEND,
// masks and prioritises them, and presents one active interrupt at a time to
// the core. Software reaches PEND/MASK/STAT/EOI through a 4-word window on
// the data bus.
module nrisc_irq_ctrl
    import nrisc_irq_ctrl_pkg::*;
#(
    parameter int                 TAM       = TAM_DEFAULT,
    parameter int                 N_DData   = N_DDATA_DEFAULT,
    parameter logic [N_DData-1:0] BASE_ADDR = N_DData'(BASE_ADDR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         irq_src,
    input  logic [N_DData-1:0] dbus_addr,
    input  logic [TAM-1:0]     dbus_wdata,
    input  logic               dbus_load,
    input  logic               dbus_write,
    output logic [TAM-1:0]     dbus_rdata,
    output logic               dbus_sel,
    output logic [7:0]         INTERRUPT_ch,
    output logic               INTERRUPT_flag
);

    logic [7:0]     src_prev;
    logic [7:0]     pend_q;
    logic [7:0]     mask_q;
    logic [0:0]     state_q;
    logic [2:0]     ch_q;

    logic           in_win;
    logic [1:0]     reg_off;
    logic           wr_pend;
    logic           wr_mask;
    logic           wr_eoi;
    logic           rd_hit;
    logic           active;
    logic [7:0]     rise;
    logic [7:0]     pend_clear;
    logic [7:0]     eoi_clear;
    logic [7:0]     pend_next;
    logic [7:0]     cand;
    logic [2:0]     win_idx;
    logic           win_valid;
    logic [2:0]     active_ch;
    logic [TAM-1:0] stat_word;
    logic [TAM-1:0] rd_word;

    assign in_win    = (dbus_addr[N_DData-1:2] == BASE_ADDR[N_DData-1:2]);
    assign reg_off   = dbus_addr[1:0];
    assign wr_pend   = dbus_write && in_win && (reg_off == OFF_PEND);
    assign wr_mask   = dbus_write && in_win && (reg_off == OFF_MASK);
    assign wr_eoi    = dbus_write && in_win && (reg_off == OFF_EOI);
    assign rd_hit    = dbus_load && in_win;
    assign active    = (state_q == ST_ACTIVE);
    assign active_ch = active ? ch_q : 3'd0;

    // An edge sets PEND even when the same bit is being cleared this cycle
    assign rise       = irq_src & ~src_prev;
    assign pend_clear = wr_pend ? dbus_wdata[7:0] : 8'h00;
    assign eoi_clear  = (active && wr_eoi) ? onehot8(ch_q) : 8'h00;
    assign pend_next  = (pend_q & ~(pend_clear | eoi_clear)) | rise;

    assign cand = pend_q & mask_q;

    nrisc_prio_enc8 u_prio (
        .req   (cand),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // STAT puts the active bit at position 8, which only exists on wide buses
    generate
        if (TAM > 8) begin : g_stat_wide
            assign stat_word = TAM'({active, 5'b00000, active_ch});
            wire unused_wdata_hi = ^dbus_wdata[TAM-1:8];
        end else begin : g_stat_narrow
            assign stat_word = TAM'({5'b00000, active_ch});
        end
    endgenerate

    // Read mux over the window; EOI reads as zero
    always_comb begin
        rd_word = '0;
        case (reg_off)
            OFF_PEND: rd_word = TAM'(pend_q);
            OFF_MASK: rd_word = TAM'(mask_q);
            OFF_STAT: rd_word = stat_word;
            default:  rd_word = '0;
        endcase
    end

    // Edge history, PEND and MASK registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_prev <= 8'h00;
            pend_q   <= 8'h00;
            mask_q   <= 8'h00;
        end else begin
            src_prev <= irq_src;
            pend_q   <= pend_next;
            if (wr_mask) begin
                mask_q <= dbus_wdata[7:0];
            end
        end
    end

    // Interrupt FSM: take the winner when idle, stay until EOI
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ch_q    <= 3'd0;
        end else if (state_q == ST_IDLE) begin
            if (win_valid) begin
                state_q <= ST_ACTIVE;
                ch_q    <= win_idx;
            end
        end else if (wr_eoi) begin
            state_q <= ST_IDLE;
        end
    end

    // Registered read port; data holds between loads, select only on a hit
    always_ff @(posedge clk) begin
        if (!rst) begin
            dbus_rdata <= '0;
            dbus_sel   <= 1'b0;
        end else begin
            dbus_sel <= rd_hit;
            if (rd_hit) begin
                dbus_rdata <= rd_word;
            end
        end
    end

    assign INTERRUPT_flag = active;
    assign INTERRUPT_ch   = {5'b00000, active_ch};

endmodule

// File: tb/tb_nrisc_irq_ctrl.sv
// Self-checking bench for nrisc_irq_ctrl: directed scenarios followed by a
// randomized run, all compared against a bit-level behavioural model.
module tb_nrisc_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_src;
    logic [15:0] dbus_addr;
    logic [15:0] dbus_wdata;
    logic        dbus_load;
    logic        dbus_write;
    logic [15:0] dbus_rdata;
    logic        dbus_sel;
    logic [7:0]  INTERRUPT_ch;
    logic        INTERRUPT_flag;

    int nCompared = 0;
    int nFailed   = 0;

    // Reference model state
    bit          mPend [8];
    bit          mMask [8];
    bit          mPrev [8];
    bit          mActive;
    int          mCh;
    logic [15:0] mRdata;
    bit          mSel;

    nrisc_irq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .irq_src        (irq_src),
        .dbus_addr      (dbus_addr),
        .dbus_wdata     (dbus_wdata),
        .dbus_load      (dbus_load),
        .dbus_write     (dbus_write),
        .dbus_rdata     (dbus_rdata),
        .dbus_sel       (dbus_sel),
        .INTERRUPT_ch   (INTERRUPT_ch),
        .INTERRUPT_flag (INTERRUPT_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] packBits(input bit b [8]);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < 8; i++) v = v + (b[i] ? (16'd1 << i) : 16'd0);
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelStep();
        bit inWin;
        int off;
        bit nextPend [8];
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                mPend[i] = 0; mMask[i] = 0; mPrev[i] = 0;
            end
            mActive = 0; mCh = 0; mRdata = 16'h0000; mSel = 0;
            return;
        end
        inWin = (dbus_addr / 4) == (BASE / 4);
        off   = dbus_addr % 4;
        mSel  = dbus_load && inWin;
        if (mSel) begin
            if (off == 0)      mRdata = packBits(mPend);
            else if (off == 1) mRdata = packBits(mMask);
            else if (off == 2) mRdata = mActive ? (16'h0100 + 16'(mCh)) : 16'h0000;
            else               mRdata = 16'h0000;
        end
        for (int i = 0; i < 8; i++) begin
            bit edgeSeen, clearReq;
            edgeSeen = irq_src[i] && !mPrev[i];
            clearReq = (dbus_write && inWin && off == 0 && dbus_wdata[i]) ||
                       (dbus_write && inWin && off == 3 && mActive && mCh == i);
            nextPend[i] = edgeSeen ? 1'b1 : (clearReq ? 1'b0 : mPend[i]);
        end
        if (!mActive) begin
            for (int i = 7; i >= 0; i--) begin
                if (mPend[i] && mMask[i]) begin
                    mActive = 1; mCh = i;
                end
            end
        end else if (dbus_write && inWin && off == 3) begin
            mActive = 0;
        end
        if (dbus_write && inWin && off == 1) begin
            for (int i = 0; i < 8; i++) mMask[i] = dbus_wdata[i];
        end
        for (int i = 0; i < 8; i++) begin
            mPend[i] = nextPend[i];
            mPrev[i] = irq_src[i];
        end
    endtask

    task automatic expectEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model
    task automatic checkOutput();
        expectEq("flag", 16'(INTERRUPT_flag), 16'(mActive));
        expectEq("ch", 16'(INTERRUPT_ch), mActive ? 16'(mCh) : 16'h0000);
        expectEq("sel", 16'(dbus_sel), 16'(mSel));
        expectEq("rdata", dbus_rdata, mRdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // One bus operation for one cycle, then return the strobes to idle
    task automatic applyStimulus(input bit ld, input bit wr, input logic [15:0] addr,
                                 input logic [15:0] wdata);
        dbus_load  = ld;
        dbus_write = wr;
        dbus_addr  = addr;
        dbus_wdata = wdata;
        cycle();
        dbus_load  = 1'b0;
        dbus_write = 1'b0;
        dbus_addr  = 16'h0000;
        dbus_wdata = 16'h0000;
    endtask

    task automatic idle(); applyStimulus(0, 0, 16'h0000, 16'h0000); endtask
    task automatic rdReg(input int off); applyStimulus(1, 0, BASE + 16'(off), 16'h0000); endtask
    task automatic wrReg(input int off, input logic [15:0] d); applyStimulus(0, 1, BASE + 16'(off), d); endtask

    initial begin
        rst = 1'b0; irq_src = 8'h00;
        dbus_addr = 16'h0000; dbus_wdata = 16'h0000;
        dbus_load = 1'b0; dbus_write = 1'b0;
        for (int i = 0; i < 8; i++) begin mPend[i] = 0; mMask[i] = 0; mPrev[i] = 0; end
        mActive = 0; mCh = 0; mRdata = 16'h0000; mSel = 0;

        // Reset with all sources high
        irq_src = 8'hFF;
        repeat (3) idle();
        expectEq("rst_flag", 16'(INTERRUPT_flag), 16'h0000);
        expectEq("rst_ch", 16'(INTERRUPT_ch), 16'h0000);
        rst = 1'b1;
        idle();
        rdReg(0);
        expectEq("pend_after_rst", dbus_rdata, 16'h00FF);
        expectEq("flag_masked", 16'(INTERRUPT_flag), 16'h0000);
        irq_src = 8'h00;
        wrReg(0, 16'h00FF);

        // Single interrupt on channel 4
        wrReg(1, 16'h0010);
        irq_src = 8'h10; idle();
        irq_src = 8'h00; idle();
        expectEq("single_flag", 16'(INTERRUPT_flag), 16'h0001);
        expectEq("single_ch", 16'(INTERRUPT_ch), 16'h0004);
        rdReg(2);
        expectEq("single_stat", dbus_rdata, 16'h0104);
        wrReg(3, 16'h0000);
        expectEq("eoi_flag", 16'(INTERRUPT_flag), 16'h0000);
        rdReg(0);
        expectEq("eoi_pend", dbus_rdata, 16'h0000);

        // Priority between channels 6 and 2
        wrReg(1, 16'h00FF);
        irq_src = 8'h44; idle();
        irq_src = 8'h00; idle();
        expectEq("prio_ch", 16'(INTERRUPT_ch), 16'h0002);
        wrReg(3, 16'h0000);
        expectEq("prio_gap", 16'(INTERRUPT_flag), 16'h0000);
        idle();
        expectEq("prio_next_ch", 16'(INTERRUPT_ch), 16'h0006);
        wrReg(3, 16'h0000);
        idle();

        // No preemption by a higher-priority source
        irq_src = 8'h20; idle();
        irq_src = 8'h00; idle();
        irq_src = 8'h01; idle();
        irq_src = 8'h00; idle();
        expectEq("nopre_ch", 16'(INTERRUPT_ch), 16'h0005);
        rdReg(0);
        expectEq("nopre_pend", dbus_rdata, 16'h0021);
        wrReg(3, 16'h0000);
        idle();
        expectEq("nopre_next", 16'(INTERRUPT_ch), 16'h0000);
        wrReg(3, 16'h0000);

        // Edge and W1C on the same bit
        wrReg(1, 16'h0000);
        irq_src = 8'h08;
        wrReg(0, 16'h0008);
        irq_src = 8'h00;
        rdReg(0);
        expectEq("collide_pend", dbus_rdata, 16'h0008);

        // Reset in the middle of an interrupt
        wrReg(0, 16'h00FF);
        wrReg(1, 16'h0002);
        irq_src = 8'h02; idle();
        irq_src = 8'h00; idle();
        expectEq("mid_ch", 16'(INTERRUPT_ch), 16'h0001);
        rst = 1'b0; idle(); rst = 1'b1;
        expectEq("mid_flag", 16'(INTERRUPT_flag), 16'h0000);
        rdReg(1);
        expectEq("mid_mask", dbus_rdata, 16'h0000);
        rdReg(2);
        expectEq("mid_stat", dbus_rdata, 16'h0000);
        wrReg(3, 16'h0000);
        idle();
        expectEq("mid_eoi_idle", 16'(INTERRUPT_flag), 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int op;
            logic [15:0] addr;
            irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            rst = ($urandom_range(0, 59) != 0);
            op = $urandom_range(0, 9);
            dbus_load  = $urandom_range(0, 1) == 1;
            dbus_write = 1'b0;
            dbus_wdata = 16'($urandom);
            addr = (op == 5) ? 16'hFF04 : BASE + 16'($urandom_range(0, 3));
            if (op <= 1)      begin dbus_write = 1'b1; addr = BASE + 16'd1; end
            else if (op == 2) begin dbus_write = 1'b1; addr = BASE + 16'd0; end
            else if (op <= 4) begin dbus_write = 1'b1; addr = BASE + 16'd3; end
            else if (op == 5) dbus_write = 1'b1;
            if ($urandom_range(0, 7) == 0) addr = 16'h0F00 + 16'($urandom_range(0, 3));
            dbus_addr = addr;
            cycle();
        end
        rst = 1'b1;
        dbus_load = 1'b0; dbus_write = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/nrisc_irq_ctrl.md
# nrisc_irq_ctrl

Interrupt controller that sits directly upstream of the NRISC_UP core's interrupt inputs. It collects eight peripheral request lines, latches rising edges into a pending register, applies a software mask and fixed priority, and drives the core's 8-bit interrupt channel and interrupt flag. It is also a memory-mapped slave on the core's data bus, which software uses to program the mask, inspect pending and active state, and signal end-of-interrupt.

## Interface
- TAM, 16, data bus width; must be ≥ 8.
- N_DData, 16, data address width.
- BASE_ADDR, 16'hFF00, base of the 4-word register window; the low 2 bits must be 0.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active low.
- irq_src  in  8  peripheral requests; level signals, synchronous to clk.
- dbus_addr  in  N_DData  core data address.
- dbus_wdata  in  TAM  core write data.
- dbus_load  in  1  core read strobe.
- dbus_write  in  1  core write strobe.
- dbus_rdata  out  TAM  read data to core, registered.
- dbus_sel  out  1  registered; high when this block answers the read issued in the previous cycle.
- INTERRUPT_ch  out  8  channel index of the active interrupt, zero-extended.
- INTERRUPT_flag  out  1  high while an interrupt is active.

## Operation
- **Register window** (word offsets from BASE_ADDR): 0 PEND, 1 MASK, 2 STAT, 3 EOI. Any address outside the window is ignored.
- **PEND** (8b, read; write-1-to-clear): bit i sets on a rising edge of irq_src[i]. Edge detection uses a 1-flop history, so an edge is prev=0, cur=1. Mask does not gate setting.
- **MASK** (8b, read/write): 1 = enabled. Reset value is 0, so everything is masked.
- **STAT** (read only): bit 8 = active; bits [2:0] = active channel; other bits 0.
- **EOI** (write only, data ignored): ends the active interrupt. It is a no-op when the controller is IDLE.
- Reads of EOI return 0. Unused upper bits read 0 and are ignored on write.
- **Priority**: candidates = PEND & MASK; the lowest index wins.
- **FSM states**:
  - IDLE: if candidates ≠ 0, latch the winning index into ch_q and go to ACTIVE.
  - ACTIVE: INTERRUPT_flag=1 and INTERRUPT_ch=ch_q. There is no preemption; new pending bits accumulate. An EOI write clears PEND[ch_q] and returns to IDLE.
- **Masking while active**: clearing MASK[ch_q] while ACTIVE does not abort the interrupt. Only EOI or reset leaves ACTIVE.
- **Simultaneous set and clear** of the same PEND bit (edge plus W1C, or edge plus EOI clear) in one cycle: set wins, so the bit stays 1.
- **Reset** (rst=0 at a clock edge, including mid-interrupt) clears:
  - PEND, MASK and edge history;
  - state (to IDLE) and ch_q;
  - dbus_rdata, dbus_sel, INTERRUPT_flag and INTERRUPT_ch.
- **First cycle after reset**: the history is 0, so a source already high produces an edge and sets PEND.

## Timing
- Edge to PEND: irq_src rises before edge k; PEND bit is 1 after edge k.
- PEND to flag: IDLE with an enabled pending bit at edge k+1 → INTERRUPT_flag high after edge k+1. Edge-to-flag latency is 2 cycles.
- EOI to next interrupt: EOI written at edge m → IDLE and flag low after m. A further candidate raises the flag after m+1, giving at least 1 low cycle between interrupts.
- Outputs INTERRUPT_ch and INTERRUPT_flag are registered, with no combinational path from any input.
- Reads: dbus_load at edge k → dbus_rdata and dbus_sel valid after k, held until the next load. dbus_sel drops on a cycle with no in-window load.
- Read/write collision: a read and a write in the same cycle to the same register returns the pre-write value.

## Structure
- Register offsets (PEND/MASK/STAT/EOI), state encodings (IDLE=0, ACTIVE=1) and the default BASE_ADDR are defines in the shared constants header alongside TAM/N_DData.
- One sub-module, nrisc_prio_enc8: combinational 8→3 lowest-index encoder with a valid output, reusable by future arbiters.

## Test plan
- **Reset**: hold rst=0 with irq_src=8'hFF for 3 cycles → all outputs 0 and PEND=0. Release → PEND=8'hFF after 1 edge, flag stays 0 because MASK=0.
- **Single interrupt**: write MASK=8'h10, pulse irq_src[4] → flag=1 and INTERRUPT_ch=8'h04 two cycles after the edge. STAT reads 16'h0104. Write EOI → flag=0 next cycle, PEND=0.
- **Priority**: MASK=8'hFF, raise irq_src[6] and irq_src[2] in the same cycle → INTERRUPT_ch=2. After EOI, flag returns with ch=6 after one low cycle.
- **No preemption**: ch=5 active, raise irq_src[0] → ch stays 5, PEND bit0=1. After EOI → ch=0.
- **Collision**: in the same cycle, write PEND=8'h08 (W1C) and give irq_src[3] a rising edge → PEND[3] remains 1.
- **Mid-interrupt reset**: ch=1 active, drive rst=0 for one edge → flag=0, MASK=0 and STAT=0. An EOI written after reset leaves the block IDLE.
